// File: rtl/router_port_injector.sv
`timescale 1ns/1ps
// Source-side injector for one router input port: queues host words tagged with a
// destination and presents them on a valid/ready lane without ever retracting a word.
module router_port_injector #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [1:0]            wr_dest,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [1:0]            destination,
   output logic                  valid,
   input  logic                  ready,
   output logic [CNT_WIDTH-1:0]  sent_count,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic                  overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [AW:0]          FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]          COUNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t        state, state_next;
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop, drop, handshake;

   assign full      = (count == FULL_LEVEL);
   assign empty     = (count == '0);
   assign valid     = (state == PRESENT);
   assign push      = wr_en && !full;
   assign drop      = wr_en && full;
   assign handshake = valid && ready;

   // Output stage: a presented word is held until accepted; enable only gates new launches.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && enable) begin
               pop        = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (ready) begin
               if (!empty && enable) pop = 1'b1;
               else                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Storage array needs no reset; occupancy tracking alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_dest, wr_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out    <= '0;
         destination <= '0;
      end else if (pop) begin
         {destination, data_out} <= mem[rd_ptr];
      end
   end

   // Statistics: counters wrap naturally, overflow is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent_count <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (handshake) sent_count <= sent_count + CNT_ONE;
         if (drop) begin
            drop_count <= drop_count + CNT_ONE;
            overflow   <= 1'b1;
         end
      end
   end

endmodule

// File: doc/router_port_injector.md
# router_port_injector

Source-side driver for one input port of the 4-port buffered router. It accepts words tagged with a 2-bit destination from a host and queues them in a FIFO. It presents each word to the router's data_in, destination and valid lane with ready backpressure. Four instances feed the router's four input ports, so tests and traffic engines can inject streams without hand-timing the router inputs.

## Interface
- DATA_WIDTH, 8, payload width; matches router data width
- DEPTH, 8, FIFO entries (power of two, ≥2), excluding output register
- CNT_WIDTH, 16, width of sent/dropped counters
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  permits launching new words toward router
- wr_en  input  1  host write strobe
- wr_data  input  DATA_WIDTH  host payload
- wr_dest  input  2  host destination port (0–3)
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries (output register may still hold a word)
- data_out  output  DATA_WIDTH  payload to router data_in
- destination  output  2  destination to router
- valid  output  1  data_out/destination hold a word
- ready  input  1  router accepts word this cycle
- sent_count  output  CNT_WIDTH  words handed to router
- drop_count  output  CNT_WIDTH  host writes discarded while full
- overflow  output  1  sticky; set on first dropped write

## Operation
- FIFO stores {wr_dest, wr_data}. Write pointer, read pointer and an occupancy count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Output stage FSM:
  - IDLE: valid=0. Move to PRESENT at the next edge when FIFO is non-empty and enable=1. Pop the head into data_out/destination.
  - PRESENT: valid=1. On handshake (valid&&ready at an edge), sent_count increments. Then, if FIFO is non-empty and enable=1, pop the next head and stay in PRESENT. Otherwise go to IDLE.
- No retraction: while valid&&!ready, data_out, destination and valid stay constant, even if enable falls. enable only gates new launches.
- Write when not full: entry stored. Write when full: entry discarded, drop_count increments, overflow=1. Drop applies even if a pop occurs in the same cycle.
- Simultaneous write and pop when not full: both occur; count unchanged.
- Counters wrap at 2^CNT_WIDTH. overflow clears only on reset.
- full and empty are decoded combinationally from the occupancy count.

## Timing
- Reset (rst=0, asynchronous) values:
  - valid=0, data_out=0, destination=0
  - FSM state IDLE, pointers and count 0
  - empty=1, full=0
  - sent_count=0, drop_count=0, overflow=0
- Reset mid-transfer discards all queued and presented words immediately. Outputs return to their reset values without waiting for a clock.
- Latency: a word written at edge k into an empty FIFO, with enable=1 and valid=0, appears with valid=1 after edge k+1.
- Throughput: with ready held at 1 and FIFO non-empty, one word is transferred per cycle with no bubbles.
- A word popped into the output register frees its FIFO slot at the same edge. full deasserts after that edge.
- Words leave in write order; there is no reordering by destination.

## Test plan
- Reset, then write A1/0, B2/1, C3/2, D4/3 on consecutive cycles with ready=1 and enable=1. Required:
  - valid high from the edge after the first write
  - data_out/destination sequence A1/0, B2/1, C3/2, D4/3 on consecutive cycles
  - sent_count=4, then valid=0 and empty=1
- Present 55/2 with ready=0 for 5 cycles, dropping enable in the middle. Required: valid, data_out and destination stay steady at 55/2. Raise ready for 1 cycle: sent_count increments by 1.
- With ready=0, write DEPTH+1 words (first goes to output register, DEPTH fill FIFO), then one more. Required: full=1, drop_count=1, overflow=1. Raise ready: all DEPTH+1 stored words emerge in order and no dropped word appears.
- With full=1 and ready=1, write in the same cycle as a handshake. Required: write dropped, drop_count increments, FIFO count decrements by 1.
- Assert rst=0 asynchronously between edges while valid=1 with 3 words queued. Required: valid=0 and empty=1 immediately. After release, the next write AA/3 appears as the only output.
- Hold enable=0, write 3 words, then raise enable with ready=1. Required: no valid before enable; 3 words out on consecutive cycles, with the first valid after the edge where enable=1 is sampled.
